router_pkt_tx: RTL and testbench

Source-side packet transmitter for the 1x3 router. It accepts a packet request (destination port and payload length) and the payload bytes from an upstream client, buffering the whole payload first. It then drives the router input interface (`pkt_valid`, data byte, `busy`) with header, payload and parity as one contiguous burst. Full buffering is required because the router protocol has no bubble mechanism: once `pkt_valid` rises, a valid byte must be offered every cycle until the parity byte.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_tx_buf.sv | 23 ++
 rtl/router_pkt_tx.sv | 188 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router and its source-side transmitter.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] PORT_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_t;

  // Header byte carries the payload length above the destination port.
  function automatic logic [DATA_W-1:0] build_header(input logic [LEN_W-1:0]  len,
                                                     input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<LEN_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter: buffers a full payload, then drives the
// router with header, payload and parity as one uninterrupted burst.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              done,
  output logic              bad_req
);

  localparam int GAP_W = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP);

  tx_state_t         state, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [DATA_W-1:0] hdr_q, hdr_n;
  logic [DATA_W-1:0] par_q, par_n;
  logic [LEN_W-1:0]  wptr, wptr_n;
  logic [LEN_W-1:0]  rptr, rptr_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;

  logic              pkt_valid_n;
  logic [DATA_W-1:0] tx_data_n;
  logic              done_n;
  logic              bad_req_n;
  logic              wr_en;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Look one byte ahead so tx_data can be registered on the consuming edge.
  assign rd_addr = (state == PAYLOAD) ? rptr + 1'b1 : '0;

  router_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (pay_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    hdr_n       = hdr_q;
    par_n       = par_q;
    wptr_n      = wptr;
    rptr_n      = rptr;
    gap_n       = gap_cnt;
    pkt_valid_n = pkt_valid;
    tx_data_n   = tx_data;
    done_n      = 1'b0;
    bad_req_n   = 1'b0;
    wr_en       = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr == PORT_INVALID) begin
            bad_req_n = 1'b1;
          end else begin
            len_n  = req_len;
            hdr_n  = build_header(req_len, req_addr);
            par_n  = hdr_n;
            wptr_n = '0;
            rptr_n = '0;
            if (req_len == '0) begin
              state_n     = HEADER;
              pkt_valid_n = 1'b1;
              tx_data_n   = hdr_n;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end

      LOAD: begin
        if (pay_valid) begin
          wr_en  = 1'b1;
          par_n  = par_q ^ pay_data;
          wptr_n = wptr + 1'b1;
          if (wptr == len_q - 1'b1) begin
            state_n     = HEADER;
            pkt_valid_n = 1'b1;
            tx_data_n   = hdr_q;
          end
        end
      end

      HEADER: begin
        if (!busy) begin
          if (len_q == '0) begin
            state_n     = PARITY;
            pkt_valid_n = 1'b0;
            tx_data_n   = par_q;
          end else begin
            state_n   = PAYLOAD;
            rptr_n    = '0;
            tx_data_n = rd_data;
          end
        end
      end

      PAYLOAD: begin
        if (!busy) begin
          if (rptr == len_q - 1'b1) begin
            state_n     = PARITY;
            pkt_valid_n = 1'b0;
            tx_data_n   = par_q;
          end else begin
            rptr_n    = rptr + 1'b1;
            tx_data_n = rd_data;
          end
        end
      end

      PARITY: begin
        if (!busy) begin
          state_n   = GAP;
          done_n    = 1'b1;
          gap_n     = '0;
          tx_data_n = '0;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        pkt_valid_n = 1'b0;
      end
    endcase
  end

  // Handshake readies are registered from the next state so they line up
  // with the cycle the FSM actually sits in IDLE or LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      hdr_q     <= '0;
      par_q     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      gap_cnt   <= '0;
      pkt_valid <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
      bad_req   <= 1'b0;
      req_ready <= 1'b1;
      pay_ready <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      hdr_q     <= hdr_n;
      par_q     <= par_n;
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      gap_cnt   <= gap_n;
      pkt_valid <= pkt_valid_n;
      tx_data   <= tx_data_n;
      done      <= done_n;
      bad_req   <= bad_req_n;
      req_ready <= (state_n == IDLE);
      pay_ready <= (state_n == LOAD);
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues expected router bytes,
// a negedge monitor pops and compares every byte the router would consume.
module tb_router_pkt_tx;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pay_valid;
  logic       pay_ready;
  logic [7:0] pay_data;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] tx_data;
  logic       done;
  logic       bad_req;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base = 0;
  bit in_burst = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_buf[64];

  router_pkt_tx #(.IDLE_GAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .pay_data  (pay_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .tx_data   (tx_data),
    .done      (done),
    .bad_req   (bad_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a byte is consumed on the coming edge when busy is low.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_burst = 0;
    end else begin
      if (done) done_cnt++;
      if (pkt_valid) begin
        in_burst = 1;
        if (!busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
          end else begin
            checkOutput("burst_byte", tx_data, exp_q.pop_front());
          end
        end
      end else if (in_burst && !busy) begin
        checkOutput("burst_remaining", exp_q.size(), 1);
        if (exp_q.size() > 0) checkOutput("parity", tx_data, exp_q.pop_front());
        in_burst = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len,
                               input logic [7:0] hdr_exp, input bit toggle);
    logic [7:0] par;
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("req_ready_wait", req_ready, 1);
    par = hdr_exp;
    exp_q.push_back(hdr_exp);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_buf[i]);
      par ^= pay_buf[i];
    end
    exp_q.push_back(par);
    done_base = done_cnt;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (toggle) begin
        pay_valid = 1'b0;
        @(posedge clk); #1;
      end
      pay_valid = 1'b1;
      pay_data  = pay_buf[i];
      n = 0;
      while (!pay_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 50) checkOutput("pay_ready_timeout", pay_ready, 1);
      @(posedge clk); #1;
      pay_valid = 1'b0;
    end
  endtask

  task automatic waitForDone();
    int n;
    n = 0;
    while (done_cnt == done_base && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("done_seen", done_cnt - done_base, 1);
    checkOutput("queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_cnt - done_base, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pay_valid = 1'b0; pay_data = '0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_pkt_valid", pkt_valid, 0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_bad_req", bad_req, 0);
    checkOutput("rst_pay_ready", pay_ready, 0);

    $display("[TB] len 14 addr 0, busy low");
    for (int i = 0; i < 14; i++) pay_buf[i] = 8'h10 + 8'(i);
    applyStimulus(2'd0, 6'd14, 8'h38, 0);
    checkOutput("hdr_latency_valid", pkt_valid, 1);
    checkOutput("hdr_latency_data", tx_data, 8'h38);
    checkOutput("req_ready_busy_pkt", req_ready, 0);
    waitForDone();

    $display("[TB] len 8 addr 1, busy stall on byte 4");
    for (int i = 0; i < 8; i++) pay_buf[i] = 8'hA0 ^ 8'(i * 17);
    applyStimulus(2'd1, 6'd8, 8'h21, 0);
    repeat (5) @(posedge clk);
    #1 busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("busy_hold_data", tx_data, pay_buf[4]);
      checkOutput("busy_hold_valid", pkt_valid, 1);
      @(posedge clk); #1;
    end
    busy = 1'b0;
    checkOutput("busy_release_data", tx_data, pay_buf[4]);
    waitForDone();

    $display("[TB] len 0 addr 2");
    applyStimulus(2'd2, 6'd0, 8'h02, 0);
    checkOutput("len0_hdr_valid", pkt_valid, 1);
    checkOutput("len0_hdr_data", tx_data, 8'h02);
    @(posedge clk); #1;
    checkOutput("len0_par_valid", pkt_valid, 0);
    checkOutput("len0_par_data", tx_data, 8'h02);
    waitForDone();

    $display("[TB] illegal port 3");
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bad_req_pulse", bad_req, 1);
    checkOutput("bad_req_pkt_valid", pkt_valid, 0);
    checkOutput("bad_req_req_ready", req_ready, 1);
    checkOutput("bad_req_pay_ready", pay_ready, 0);
    @(posedge clk); #1;
    checkOutput("bad_req_clear", bad_req, 0);
    checkOutput("bad_req_pay_ready2", pay_ready, 0);

    $display("[TB] len 63 addr 0, toggling pay_valid");
    for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i * 3 + 7);
    applyStimulus(2'd0, 6'd63, 8'hFC, 1);
    waitForDone();

    $display("[TB] reset mid-packet");
    for (int i = 0; i < 20; i++) pay_buf[i] = 8'h55 + 8'(i);
    applyStimulus(2'd2, 6'd20, 8'h52, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre_rst_byte5", tx_data, pay_buf[5]);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_pkt_valid", pkt_valid, 0);
    checkOutput("mid_rst_tx_data", tx_data, 8'h00);
    checkOutput("mid_rst_req_ready", req_ready, 1);
    rst = 1'b0;

    $display("[TB] len 3 addr 1, busy high at header");
    pay_buf[0] = 8'hDE; pay_buf[1] = 8'hAD; pay_buf[2] = 8'hBE;
    busy = 1'b1;
    applyStimulus(2'd1, 6'd3, 8'h0D, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("hdr_busy_hold", tx_data, 8'h0D);
      @(posedge clk); #1;
    end
    busy = 1'b0;
    waitForDone();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
